// File: rtl/router_pkg.sv
// Shared definitions for the nibble stream router: channel-index width helper,
// drop counter width and the arbiter pointer type.
package router_pkg;

    // Drop statistics counter width per channel.
    localparam int unsigned DROP_CNT_W = 16;

    // Largest supported channel count; the arbiter pointer is sized for it.
    localparam int unsigned MAX_CH = 16;

    // Arbiter pointer wide enough for any supported channel count.
    typedef logic [$clog2(MAX_CH)-1:0] arb_ptr_t;

    // Channel index width: never narrower than one bit.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/router_chan_fifo.sv
// Single-channel synchronous FIFO for the nibble stream router.
// Read data is presented combinationally from the head entry; full/empty are
// derived from the registered count so they change only after a clock edge.
module router_chan_fifo #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    // Qualify requests against the current (pre-edge) occupancy.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    // Pointer and count next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Status outputs taken from the registered count.
    always_comb begin
        pop_data = mem[rd_ptr_q];
        count    = cnt_q;
        full     = (cnt_q == CNT_W'(DEPTH));
        empty    = (cnt_q == '0);
    end

endmodule

// File: rtl/nibble_stream_router.sv
// Nibble stream router: steers a tagged word stream into NUM_CH channel FIFOs
// and drains them through a registered round-robin arbiter to one output.
// Writes to a full FIFO or an out-of-range channel are dropped and flagged.
// Optional macro ROUTER_DROP_STATS_EN adds per-channel saturating drop counters;
// without it outDropCount is tied to zero.
module nibble_stream_router
    import router_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CH_W  = ch_w(NUM_CH)
) (
    input  logic                         inClock,
    input  logic                         inReset,
    input  logic [DATA_W-1:0]            inData,
    input  logic                         inValid,
    input  logic [CH_W-1:0]              inDest,
    input  logic                         inReadEnable,
    output logic [DATA_W-1:0]            outData,
    output logic                         outValid,
    output logic [CH_W-1:0]              outSrc,
    output logic [NUM_CH-1:0]            outFull,
    output logic [NUM_CH-1:0]            outEmpty,
    output logic                         outDrop,
    output logic [NUM_CH*DROP_CNT_W-1:0] outDropCount
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0] fifo_push;
    logic [NUM_CH-1:0] fifo_pop;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [DATA_W-1:0] fifo_rdata [NUM_CH];
    logic [CNT_W-1:0]  fifo_count [NUM_CH];

    logic              dest_hit;
    logic              dest_full;
    logic              accept;
    logic              drop;

    logic              load;
    logic              grant_valid;
    arb_ptr_t          grant_idx;
    logic [DATA_W-1:0] grant_data;

    arb_ptr_t          ptr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              drop_q;

    // Channel FIFOs.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        router_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (inClock),
            .rst       (inReset),
            .push      (fifo_push[ch]),
            .push_data (inData),
            .pop       (fifo_pop[ch]),
            .pop_data  (fifo_rdata[ch]),
            .full      (fifo_full[ch]),
            .empty     (fifo_empty[ch]),
            .count     (fifo_count[ch])
        );
    end

    // Write side: decode destination, accept against the pre-edge count, else drop.
    always_comb begin
        dest_hit  = 1'b0;
        dest_full = 1'b0;
        fifo_push = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (inDest == CH_W'(ch)) begin
                dest_hit  = 1'b1;
                dest_full = (fifo_count[ch] == CNT_W'(DEPTH));
            end
        end
        accept = inValid && dest_hit && !dest_full;
        drop   = inValid && !accept;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            fifo_push[ch] = accept && (inDest == CH_W'(ch));
        end
    end

    // Round-robin grant: first non-empty channel above ptr, then wrap to 0..ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr_q;
        grant_data  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!grant_valid && !fifo_empty[ch] && (arb_ptr_t'(ch) > ptr_q)) begin
                grant_valid = 1'b1;
                grant_idx   = arb_ptr_t'(ch);
                grant_data  = fifo_rdata[ch];
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!grant_valid && !fifo_empty[ch] && (arb_ptr_t'(ch) <= ptr_q)) begin
                grant_valid = 1'b1;
                grant_idx   = arb_ptr_t'(ch);
                grant_data  = fifo_rdata[ch];
            end
        end
    end

    // Output register may load when empty or when its word is being consumed.
    always_comb begin
        load     = !out_valid_q || inReadEnable;
        fifo_pop = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            fifo_pop[ch] = load && grant_valid && (grant_idx == arb_ptr_t'(ch));
        end
    end

    // Output word, valid, arbiter pointer and the one-cycle drop pulse.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= drop;
            if (load) begin
                out_valid_q <= grant_valid;
                if (grant_valid) begin
                    out_data_q <= grant_data;
                    ptr_q      <= grant_idx;
                end
            end
        end
    end

`ifdef ROUTER_DROP_STATS_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q [NUM_CH];
    logic [CH_W-1:0]       drop_slot;

    // Out-of-range destinations are charged to the last channel.
    always_comb begin
        drop_slot = dest_hit ? inDest : CH_W'(NUM_CH - 1);
    end

    // Saturating per-channel drop counters, cleared only by reset.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                drop_cnt_q[ch] <= '0;
            end
        end else if (drop) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ((drop_slot == CH_W'(ch)) && (drop_cnt_q[ch] != '1)) begin
                    drop_cnt_q[ch] <= drop_cnt_q[ch] + DROP_CNT_W'(1);
                end
            end
        end
    end

    // Pack the counters into the flat output bus.
    always_comb begin
        outDropCount = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            outDropCount[DROP_CNT_W*ch +: DROP_CNT_W] = drop_cnt_q[ch];
        end
    end
`else
    assign outDropCount = '0;
`endif

    // Outputs; the pointer always holds the last granted channel, i.e. the source.
    always_comb begin
        outData  = out_data_q;
        outValid = out_valid_q;
        outSrc   = ptr_q[CH_W-1:0];
        outFull  = fifo_full;
        outEmpty = fifo_empty;
        outDrop  = drop_q;
    end

endmodule

// File: tb/tb_nibble_stream_router.sv
// Scoreboard bench for nibble_stream_router: stimulus pushes expected (data, src)
// pairs, a negedge monitor pops and compares every consumed output word.
// A second instance with NUM_CH=5 exercises out-of-range destinations.
module tb_nibble_stream_router;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] src;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  in_data;
    logic        in_valid;
    logic [1:0]  in_dest;
    logic        rd_en;
    logic [3:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_src;
    logic [3:0]  out_full;
    logic [3:0]  out_empty;
    logic        out_drop;
    logic [63:0] out_drop_count;

    logic [3:0]  b_in_data;
    logic        b_in_valid;
    logic [2:0]  b_in_dest;
    logic        b_rd_en;
    logic [3:0]  b_out_data;
    logic        b_out_valid;
    logic [2:0]  b_out_src;
    logic [4:0]  b_out_full;
    logic [4:0]  b_out_empty;
    logic        b_out_drop;
    logic [79:0] b_out_drop_count;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    nibble_stream_router #(
        .DATA_W (4),
        .NUM_CH (4),
        .DEPTH  (4)
    ) dut (
        .inClock      (clk),
        .inReset      (rst),
        .inData       (in_data),
        .inValid      (in_valid),
        .inDest       (in_dest),
        .inReadEnable (rd_en),
        .outData      (out_data),
        .outValid     (out_valid),
        .outSrc       (out_src),
        .outFull      (out_full),
        .outEmpty     (out_empty),
        .outDrop      (out_drop),
        .outDropCount (out_drop_count)
    );

    nibble_stream_router #(
        .DATA_W (4),
        .NUM_CH (5),
        .DEPTH  (4)
    ) dut5 (
        .inClock      (clk),
        .inReset      (rst),
        .inData       (b_in_data),
        .inValid      (b_in_valid),
        .inDest       (b_in_dest),
        .inReadEnable (b_rd_en),
        .outData      (b_out_data),
        .outValid     (b_out_valid),
        .outSrc       (b_out_src),
        .outFull      (b_out_full),
        .outEmpty     (b_out_empty),
        .outDrop      (b_out_drop),
        .outDropCount (b_out_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Advance one edge; inputs change and checks sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] dest, input logic [3:0] data);
        in_valid = v;
        in_dest  = dest;
        in_data  = data;
    endtask

    task automatic expect_word(input logic [3:0] data, input logic [1:0] src);
        exp_t e;
        e.data = data;
        e.src  = src;
        exp_q.push_back(e);
    endtask

    // Monitor: a word is consumed at the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && rd_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got data %0h src %0d, required none",
                         out_data, out_src);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_src", 64'(out_src), 64'(e.src));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        rd_en      = 1'b0;
        b_rd_en    = 1'b0;
        b_in_valid = 1'b0;
        b_in_dest  = '0;
        b_in_data  = '0;
        drive(1'b0, 2'd0, 4'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset then idle.
        check("rst_empty", 64'(out_empty), 64'hF);
        check("rst_full", 64'(out_full), 64'h0);
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_drop", 64'(out_drop), 64'h0);
        check("rst_src", 64'(out_src), 64'h0);

        // Single word with two-edge latency.
        rd_en = 1'b1;
        drive(1'b1, 2'd2, 4'hA);
        expect_word(4'hA, 2'd2);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        check("single_not_yet", 64'(out_valid), 64'h0);
        tick();
        check("single_valid", 64'(out_valid), 64'h1);
        tick();
        check("single_gone", 64'(out_valid), 64'h0);

        // Round-robin fairness.
        rd_en = 1'b0;
        drive(1'b1, 2'd0, 4'h1);
        tick();
        drive(1'b1, 2'd0, 4'h2);
        tick();
        drive(1'b1, 2'd1, 4'h3);
        tick();
        drive(1'b1, 2'd3, 4'h4);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        expect_word(4'h1, 2'd0);
        expect_word(4'h3, 2'd1);
        expect_word(4'h4, 2'd3);
        expect_word(4'h2, 2'd0);
        tick();
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rr_drained_valid", 64'(out_valid), 64'h0);
        check("rr_drained_empty", 64'(out_empty), 64'hF);

        // Overflow: park a ch0 word in the output so ch1 is never popped.
        rd_en = 1'b0;
        drive(1'b1, 2'd0, 4'hE);
        expect_word(4'hE, 2'd0);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'd1, 4'(i));
            expect_word(4'(i), 2'd1);
            tick();
        end
        check("ovf_full", 64'(out_full), 64'h2);
        check("ovf_no_drop_yet", 64'(out_drop), 64'h0);
        drive(1'b1, 2'd1, 4'h5);
        tick();
        check("ovf_drop", 64'(out_drop), 64'h1);
        drive(1'b0, 2'd0, 4'h0);
        tick();
        check("ovf_drop_once", 64'(out_drop), 64'h0);
`ifdef ROUTER_DROP_STATS_EN
        check("ovf_drop_count", 64'(out_drop_count[31:16]), 64'h1);
`else
        check("ovf_drop_count", out_drop_count, 64'h0);
`endif

        // Backpressure hold.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", 64'(out_valid), 64'h1);
            check("hold_data", 64'(out_data), 64'hE);
            check("hold_src", 64'(out_src), 64'h0);
            check("hold_empty", 64'(out_empty), 64'hD);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("ovf_drained", 64'(out_empty), 64'hF);

        // Out-of-range destination on the five-channel instance.
        b_in_valid = 1'b1;
        b_in_dest  = 3'd5;
        b_in_data  = 4'h3;
        tick();
        b_in_dest = 3'd7;
        check("bad5_drop", 64'(b_out_drop), 64'h1);
        check("bad5_empty", 64'(b_out_empty), 64'h1F);
        tick();
        b_in_valid = 1'b0;
        check("bad7_drop", 64'(b_out_drop), 64'h1);
        tick();
        check("bad_drop_end", 64'(b_out_drop), 64'h0);
`ifdef ROUTER_DROP_STATS_EN
        check("bad_drop_count", 64'(b_out_drop_count[79:64]), 64'h2);
`else
        check("bad_drop_count", 64'(b_out_drop_count), 64'h0);
`endif
        b_in_valid = 1'b1;
        b_in_dest  = 3'd4;
        b_in_data  = 4'h9;
        tick();
        b_in_valid = 1'b0;
        check("ch4_empty", 64'(b_out_empty), 64'h0F);
        check("ch4_no_drop", 64'(b_out_drop), 64'h0);
        tick();
        check("ch4_valid", 64'(b_out_valid), 64'h1);
        check("ch4_data", 64'(b_out_data), 64'h9);
        check("ch4_src", 64'(b_out_src), 64'h4);

        // Reset mid-operation discards everything buffered.
        rd_en = 1'b0;
        drive(1'b1, 2'd2, 4'h5);
        tick();
        drive(1'b1, 2'd2, 4'h6);
        tick();
        drive(1'b1, 2'd3, 4'h7);
        tick();
        drive(1'b1, 2'd1, 4'h8);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        tick();
        check("pre_rst_valid", 64'(out_valid), 64'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'h0);
        check("rst_mid_empty", 64'(out_empty), 64'hF);
        check("rst_mid_full", 64'(out_full), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_drop_count", out_drop_count, 64'h0);
        rd_en = 1'b1;
        drive(1'b1, 2'd0, 4'h7);
        expect_word(4'h7, 2'd0);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_idle", 64'(out_valid), 64'h0);

        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
